// File: rtl/rob_wb_pkg.sv
// ---------------------------------------------------------------------------
// rob_wb_pkg
// Shared types and constants for the ROB write-back arbiter.
//   exc_e      : exception cause carried alongside every completion result
//   SRC_*      : completion source indices (bit position in src_valid etc.)
//   *_DEF      : default widths/depths used by rob_wb_arbiter
//   rr_wrap    : modular index helper for the round-robin search
// ---------------------------------------------------------------------------
package rob_wb_pkg;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_DIV  = 2'b01,
    EXC_LS   = 2'b10,
    EXC_ADDR = 2'b11
  } exc_e;

  localparam int SRC_BR   = 0;
  localparam int SRC_ALU  = 1;
  localparam int SRC_MUL  = 2;
  localparam int SRC_DIV  = 3;
  localparam int SRC_PERM = 4;
  localparam int SRC_LSU  = 5;
  localparam int SRC_CSR  = 6;

  localparam int NUM_SRC_DEF    = 7;
  localparam int DATA_W_DEF     = 32;
  localparam int TAG_W_DEF      = 32;
  localparam int FIFO_DEPTH_DEF = 2;

  // (base + off) mod n, valid for base < n and off < n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int t;
    t = base + off;
    if (t >= n) t = t - n;
    return t;
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// ---------------------------------------------------------------------------
// wb_src_fifo
// Small skid FIFO holding completion results of one execution unit.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-low reset
//   push   in   write din (ignored while full or flushing)
//   pop    in   advance read pointer (ignored while empty or flushing)
//   flush  in   synchronous discard of all entries, wins over push/pop
//   din    in   WIDTH-bit entry
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
//   head   out  oldest entry (valid only when !empty)
// ---------------------------------------------------------------------------
module wb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rob_wb_arbiter
// Funnels completion results from NUM_SRC execution units into the single
// ROB completion write port, one result per cycle. Each source has its own
// skid FIFO; a round-robin arbiter picks among non-empty FIFOs and the
// winner is loaded into a registered valid/ready output stage.
//
// Build option:
//   WB_BR_PRIO_EN  when defined, source 0 (BR) wins whenever its FIFO is
//                  non-empty and such wins leave rr_ptr untouched; the other
//                  sources stay round-robin. Undefined: pure round-robin.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   flush      in   synchronous discard of all pending results
//   src_valid  in   per-source result valid
//   src_ready  out  per-source FIFO not full (register-derived only)
//   src_data   in   packed values, source i at [i*DATA_W +: DATA_W]
//   src_tag    in   packed instruction numbers
//   src_exc    in   packed exception causes (rob_wb_pkg::exc_e)
//   wb_valid   out  output result valid
//   wb_ready   in   ROB accepts result
//   wb_data    out  result value
//   wb_tag     out  instruction number
//   wb_exc     out  exception cause
//   wb_src     out  index of the source that produced the result
// ---------------------------------------------------------------------------
module rob_wb_arbiter
  import rob_wb_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
  input  logic [NUM_SRC*2-1:0]       src_exc,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [DATA_W-1:0]          wb_data,
  output logic [TAG_W-1:0]           wb_tag,
  output logic [1:0]                 wb_exc,
  output logic [$clog2(NUM_SRC)-1:0] wb_src
);

  localparam int SRC_W   = $clog2(NUM_SRC);
  localparam int ENTRY_W = DATA_W + TAG_W + 2;

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] pop;
  logic [ENTRY_W-1:0] head [NUM_SRC];

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   cand [NUM_SRC];
  logic               win_found;
  logic [SRC_W-1:0]   win_idx;
  logic [SRC_W-1:0]   rr_next;
  logic               load;
  logic               load_fire;

  // Per-source FIFOs. Entry layout is {exc, tag, data}.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    wb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (src_valid[g]),
      .pop   (pop[g]),
      .flush (flush),
      .din   ({src_exc[g*2 +: 2], src_tag[g*TAG_W +: TAG_W], src_data[g*DATA_W +: DATA_W]}),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );
  end

  // Ready depends only on FIFO pointer state, so upstream never sees a
  // combinational path from wb_ready or src_valid.
  assign src_ready = ~full;

  // Candidate order for this cycle: rr_ptr, rr_ptr+1, ... wrapping at NUM_SRC.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      cand[k] = SRC_W'(rr_wrap(int'(rr_ptr), k, NUM_SRC));
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef WB_BR_PRIO_EN
    if (!empty[SRC_BR]) begin
      win_found = 1'b1;
      win_idx   = SRC_W'(SRC_BR);
    end
`endif
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!win_found && !empty[cand[k]]) begin
        win_found = 1'b1;
        win_idx   = cand[k];
      end
    end
  end

  assign rr_next = (win_idx == SRC_W'(NUM_SRC-1)) ? '0 : win_idx + 1'b1;

  // The stage accepts a new result when empty or when its current one is
  // being taken this cycle; flush suppresses any transfer.
  assign load      = ~wb_valid | wb_ready;
  assign load_fire = load & win_found & ~flush;

  always_comb begin
    pop = '0;
    if (load_fire) pop[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_tag   <= '0;
      wb_exc   <= EXC_NONE;
      wb_src   <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      rr_ptr   <= '0;
    end else if (load) begin
      if (win_found) begin
        wb_valid                  <= 1'b1;
        {wb_exc, wb_tag, wb_data} <= head[win_idx];
        wb_src                    <= win_idx;
`ifdef WB_BR_PRIO_EN
        if (win_idx != SRC_W'(SRC_BR)) rr_ptr <= rr_next;
`else
        rr_ptr <= rr_next;
`endif
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule
